interrupt_sequencer: RTL and testbench

Multi-cycle controller that takes a hardware interrupt into the 5-stage pipeline. It detects and latches an interrupt request, then drains in-flight instructions by stalling fetch and inserting bubbles. It then pushes the resume PC (two 16-bit halves) and the flags onto the stack, reads the 32-bit handler address from the vector slot in data memory, and loads it into the fetch-stage PC. It sits beside the fetch and decode stages and drives their stall, clear-instruction and PC-write inputs, plus a request port into the memory stage.

---
 rtl/interrupt_pkg.sv | 22 ++
 rtl/irq_edge_latch.sv | 32 +++
 rtl/interrupt_sequencer.sv | 159 +++++++++++++++
 tb/tb_interrupt_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_pkg.sv
// Shared types and widths for the interrupt entry sequencer.
// Holds the FSM state encoding and the default vector slot address.
package interrupt_pkg;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned FLAG_W = 3;

    localparam logic [DATA_W-1:0] VECTOR_ADDR_DEF = 16'h0000;

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StPushPcH,
        StPushPcL,
        StPushFlg,
        StVecH,
        StVecL,
        StLoad
    } irq_state_t;

endpackage

// File: rtl/irq_edge_latch.sv
// Rising-edge detector with a one-deep pending latch for the interrupt request.
// A clear has priority, so an edge arriving while the request is taken is lost.
module irq_edge_latch (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_irq,
    input  logic i_clear,
    output logic o_pending
);

    logic r_irq_q;
    logic r_pending;
    logic w_rise;

    assign w_rise    = i_irq & ~r_irq_q;
    assign o_pending = r_pending;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_irq_q   <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_irq_q <= i_irq;
            if (i_clear) begin
                r_pending <= 1'b0;
            end else if (w_rise) begin
                r_pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry controller: drains the pipeline, pushes PC and flags,
// fetches the handler vector and loads it into the fetch-stage PC.
module interrupt_sequencer
    import interrupt_pkg::*;
#(
    parameter logic [DATA_W-1:0] VECTOR_ADDR  = VECTOR_ADDR_DEF,
    parameter int unsigned       DRAIN_CYCLES = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_interrupt_signal,
    input  logic              i_rti_done,
    input  logic              i_jump_pending,
    input  logic [PC_W-1:0]   i_resume_pc,
    input  logic [FLAG_W-1:0] i_flags,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_stall_fetch,
    output logic              o_clear_instruction,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic              o_mem_push,
    output logic [DATA_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_pc_write,
    output logic [PC_W-1:0]   o_pc_value,
    output logic              o_in_service
);

    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

    irq_state_t           r_state;
    irq_state_t           w_state_d;
    logic [CNT_W-1:0]     r_drain_cnt;
    logic [CNT_W-1:0]     w_drain_cnt_d;
    logic [PC_W-1:0]      r_pc_save;
    logic [DATA_W-1:0]    r_vec_hi;
    logic                 r_in_service;
    logic                 w_pending;
    logic                 w_enter;
    logic                 w_drain_exit;

    irq_edge_latch u_edge_latch (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_irq     (i_interrupt_signal),
        .i_clear   (w_enter),
        .o_pending (w_pending)
    );

    always_comb begin
        w_state_d           = r_state;
        w_drain_cnt_d       = r_drain_cnt;
        w_enter             = 1'b0;
        w_drain_exit        = 1'b0;
        o_stall_fetch       = 1'b0;
        o_clear_instruction = 1'b0;
        o_mem_req           = 1'b0;
        o_mem_we            = 1'b0;
        o_mem_push          = 1'b0;
        o_mem_addr          = '0;
        o_mem_wdata         = '0;
        o_pc_write          = 1'b0;
        o_pc_value          = '0;

        if (r_state != StIdle) begin
            o_stall_fetch       = 1'b1;
            o_clear_instruction = 1'b1;
        end

        unique case (r_state)
            StIdle: begin
                if (w_pending && !r_in_service) begin
                    w_enter       = 1'b1;
                    w_state_d     = StDrain;
                    w_drain_cnt_d = CNT_W'(DRAIN_CYCLES);
                end
            end
            StDrain: begin
                // The counter includes the current bubble, so a count of 1 or 0 is the last one.
                if (!i_jump_pending) begin
                    if (r_drain_cnt <= CNT_W'(1)) begin
                        w_drain_exit = 1'b1;
                        w_state_d    = StPushPcH;
                    end
                    if (r_drain_cnt != '0) begin
                        w_drain_cnt_d = r_drain_cnt - CNT_W'(1);
                    end
                end
            end
            StPushPcH: begin
                o_mem_req   = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_push  = 1'b1;
                o_mem_wdata = r_pc_save[PC_W-1:DATA_W];
                w_state_d   = StPushPcL;
            end
            StPushPcL: begin
                o_mem_req   = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_push  = 1'b1;
                o_mem_wdata = r_pc_save[DATA_W-1:0];
                w_state_d   = StPushFlg;
            end
            StPushFlg: begin
                o_mem_req   = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_push  = 1'b1;
                o_mem_wdata = {{(DATA_W - FLAG_W){1'b0}}, i_flags};
                w_state_d   = StVecH;
            end
            StVecH: begin
                o_mem_req  = 1'b1;
                o_mem_addr = VECTOR_ADDR;
                w_state_d  = StVecL;
            end
            StVecL: begin
                o_mem_req  = 1'b1;
                o_mem_addr = VECTOR_ADDR + DATA_W'(1);
                w_state_d  = StLoad;
            end
            StLoad: begin
                o_pc_write = 1'b1;
                o_pc_value = {r_vec_hi, i_mem_rdata};
                w_state_d  = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_drain_cnt  <= '0;
            r_pc_save    <= '0;
            r_vec_hi     <= '0;
            r_in_service <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_drain_cnt <= w_drain_cnt_d;
            // Sampled on drain exit so a branch resolved during the drain is honoured.
            if (w_drain_exit) begin
                r_pc_save <= i_resume_pc;
            end
            if (r_state == StVecL) begin
                r_vec_hi <= i_mem_rdata;
            end
            if (r_state == StLoad) begin
                r_in_service <= 1'b1;
            end else if (i_rti_done) begin
                r_in_service <= 1'b0;
            end
        end
    end

    assign o_in_service = r_in_service;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed scoreboard bench for interrupt_sequencer: pushes and PC loads are
// predicted when stimulus is driven and compared as the DUT issues them.
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        irq;
    logic        rti;
    logic        jmp;
    logic [31:0] resume_pc;
    logic [2:0]  flags;
    logic [15:0] mem_rdata;

    logic        o_stall_fetch;
    logic        o_clear_instruction;
    logic        o_mem_req;
    logic        o_mem_we;
    logic        o_mem_push;
    logic [15:0] o_mem_addr;
    logic [15:0] o_mem_wdata;
    logic        o_pc_write;
    logic [31:0] o_pc_value;
    logic        o_in_service;

    logic [15:0] mem [16];
    logic [15:0] push_q [$];
    logic [31:0] pc_q [$];

    int checks = 0;
    int errors = 0;
    int stall_run = 0;
    int last_stall = 0;
    int pcw_at = 0;
    int runs = 0;
    int runs0 = 0;
    bit found;

    always #5 clk = ~clk;

    interrupt_sequencer #(
        .VECTOR_ADDR  (16'h0000),
        .DRAIN_CYCLES (3)
    ) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_interrupt_signal  (irq),
        .i_rti_done          (rti),
        .i_jump_pending      (jmp),
        .i_resume_pc         (resume_pc),
        .i_flags             (flags),
        .i_mem_rdata         (mem_rdata),
        .o_stall_fetch       (o_stall_fetch),
        .o_clear_instruction (o_clear_instruction),
        .o_mem_req           (o_mem_req),
        .o_mem_we            (o_mem_we),
        .o_mem_push          (o_mem_push),
        .o_mem_addr          (o_mem_addr),
        .o_mem_wdata         (o_mem_wdata),
        .o_pc_write          (o_pc_write),
        .o_pc_value          (o_pc_value),
        .o_in_service        (o_in_service)
    );

    // Data memory read port: one-cycle latency.
    always @(posedge clk) begin
        if (o_mem_req && !o_mem_we) mem_rdata <= mem[o_mem_addr[3:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample after the edge and run the scoreboard monitor.
    task automatic tick();
        @(posedge clk);
        #1;
        if (o_mem_req && o_mem_we) begin
            chk("push_expected", 32'(push_q.size() != 0), 32'd1);
            chk("push_sp_path", 32'(o_mem_push), 32'd1);
            if (push_q.size() != 0) chk("push_data", 32'(o_mem_wdata), 32'(push_q.pop_front()));
        end
        if (o_pc_write) begin
            chk("pc_expected", 32'(pc_q.size() != 0), 32'd1);
            if (pc_q.size() != 0) chk("pc_value", o_pc_value, pc_q.pop_front());
        end
        if (o_stall_fetch) begin
            stall_run++;
        end else if (stall_run != 0) begin
            last_stall = stall_run;
            runs++;
            stall_run = 0;
        end
        if (o_pc_write) pcw_at = stall_run;
    endtask

    task automatic expect_entry(input logic [31:0] pc, input logic [2:0] fl, input logic [31:0] vec);
        push_q.push_back(pc[31:16]);
        push_q.push_back(pc[15:0]);
        push_q.push_back({13'b0, fl});
        pc_q.push_back(vec);
    endtask

    // Run until the current stall window closes, bounded.
    task automatic wait_done();
        int r;
        r = runs;
        for (int n = 0; n < 60 && runs == r; n++) tick();
        chk("seq_timeout", 32'(runs - r), 32'd1);
    endtask

    task automatic pulse_rti();
        rti = 1'b1;
        tick();
        rti = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; irq = 1'b0; rti = 1'b0; jmp = 1'b0;
        resume_pc = 32'h0001_2345; flags = 3'b101; mem_rdata = 16'h0;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0;
        mem[0] = 16'h0002;
        mem[1] = 16'h0100;
        #3;
        chk("rst_ctrl", {25'b0, o_stall_fetch, o_clear_instruction, o_mem_req, o_mem_we,
                         o_mem_push, o_pc_write, o_in_service}, 32'd0);
        chk("rst_addr_wdata", {o_mem_addr, o_mem_wdata}, 32'd0);
        chk("rst_pc_value", o_pc_value, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic entry.
        expect_entry(32'h0001_2345, 3'b101, 32'h0002_0100);
        irq = 1'b1;
        tick();
        chk("latency_pending_only", 32'(o_stall_fetch), 32'd0);
        tick();
        chk("drain_stall", 32'(o_stall_fetch), 32'd1);
        chk("drain_clear", 32'(o_clear_instruction), 32'd1);
        wait_done();
        chk("basic_stall_len", 32'(last_stall), 32'd9);
        chk("basic_pcw_last", 32'(pcw_at), 32'd9);
        chk("basic_in_service", 32'(o_in_service), 32'd1);
        chk("basic_q_empty", 32'(push_q.size() + pc_q.size()), 32'd0);

        // Jump pending extends the drain; PC captured at drain exit.
        irq = 1'b0;
        tick();
        pulse_rti();
        chk("rti_clears", 32'(o_in_service), 32'd0);
        mem[1] = 16'h0abc;
        flags = 3'b010;
        expect_entry(32'h0000_0040, 3'b010, 32'h0002_0abc);
        irq = 1'b1;
        tick();
        tick();
        jmp = 1'b1;
        resume_pc = 32'h0000_0040;
        tick();
        tick();
        jmp = 1'b0;
        wait_done();
        chk("jump_stall_len", 32'(last_stall), 32'd11);
        chk("jump_q_empty", 32'(push_q.size() + pc_q.size()), 32'd0);

        // Edge during service is held; a third edge while pending is dropped.
        irq = 1'b0;
        tick();
        irq = 1'b1;
        tick();
        irq = 1'b0;
        tick();
        irq = 1'b1;
        tick();
        tick();
        chk("blocked_in_service", 32'(o_stall_fetch), 32'd0);
        resume_pc = 32'h1234_5678;
        flags = 3'b011;
        expect_entry(32'h1234_5678, 3'b011, 32'h0002_0abc);
        pulse_rti();
        chk("rti_cycle_idle", 32'(o_stall_fetch), 32'd0);
        tick();
        chk("entry_after_rti", 32'(o_stall_fetch), 32'd1);
        wait_done();
        chk("held_stall_len", 32'(last_stall), 32'd9);
        irq = 1'b0;
        runs0 = runs;
        pulse_rti();
        for (int i = 0; i < 5; i++) tick();
        chk("third_edge_dropped", 32'(runs - runs0), 32'd0);

        // Reset during VEC_L aborts at once.
        resume_pc = 32'hAAAA_5555;
        flags = 3'b001;
        push_q.push_back(16'hAAAA);
        push_q.push_back(16'h5555);
        push_q.push_back(16'h0001);
        irq = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            tick();
            if (o_mem_req && !o_mem_we && o_mem_addr == 16'h0001) found = 1'b1;
        end
        chk("reached_vec_l", 32'(found), 32'd1);
        rst_n = 1'b0;
        irq = 1'b0;
        #1;
        chk("abort_ctrl", {25'b0, o_stall_fetch, o_clear_instruction, o_mem_req, o_mem_we,
                           o_mem_push, o_pc_write, o_in_service}, 32'd0);
        chk("abort_addr", 32'(o_mem_addr), 32'd0);
        chk("abort_pushes_done", 32'(push_q.size()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stall_run = 0;
        tick();

        // Fresh edge held high for 20 cycles: exactly one entry.
        resume_pc = 32'h0000_FFFF;
        flags = 3'b111;
        expect_entry(32'h0000_FFFF, 3'b111, 32'h0002_0abc);
        runs0 = runs;
        irq = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        irq = 1'b0;
        chk("level_one_entry", 32'(runs - runs0), 32'd1);
        chk("level_stall_len", 32'(last_stall), 32'd9);
        chk("level_q_empty", 32'(push_q.size() + pc_q.size()), 32'd0);
        pulse_rti();
        for (int i = 0; i < 4; i++) tick();
        chk("level_no_reentry", 32'(runs - runs0), 32'd1);

        // rti_done coincident with the LOAD-end edge: set wins.
        resume_pc = 32'h0BAD_F00D;
        flags = 3'b100;
        expect_entry(32'h0BAD_F00D, 3'b100, 32'h0002_0abc);
        irq = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 30 && !found; n++) begin
            tick();
            if (o_pc_write) found = 1'b1;
        end
        chk("reached_load", 32'(found), 32'd1);
        pulse_rti();
        chk("rti_vs_load_set_wins", 32'(o_in_service), 32'd1);
        chk("rti_load_stall_len", 32'(last_stall), 32'd9);
        chk("final_q_empty", 32'(push_q.size() + pc_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
